rf_write_arbiter: RTL

//  Shares the register file's single write port between two requesters (A: writeback, B: load/multi-cycle unit).

---
 rtl/rf_write_arbiter_if.sv | 24 ++
 rtl/rf_write_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// Requester-side handshake bundle for rf_write_arbiter: hold plus two
// valid/ready write channels (A = writeback, B = load/multi-cycle unit).
interface rf_write_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
);
  logic              hold;
  logic              a_valid, a_ready;
  logic [AWIDTH-1:0] a_sel;
  logic [DWIDTH-1:0] a_data;
  logic              b_valid, b_ready;
  logic [AWIDTH-1:0] b_sel;
  logic [DWIDTH-1:0] b_data;

  modport master (
    output hold, a_valid, a_sel, a_data, b_valid, b_sel, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  hold, a_valid, a_sel, a_data, b_valid, b_sel, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the RF write port with a registered output stage,
// read-port passthrough and per-requester grant counters. Optional RF_BYPASS_EN.
module rf_write_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_write_arbiter_if.slave req,
  output logic              rf_write,
  output logic [AWIDTH-1:0] rf_writeregsel,
  output logic [DWIDTH-1:0] rf_writedata,
  input  logic [AWIDTH-1:0] rd1_sel,
  input  logic [AWIDTH-1:0] rd2_sel,
  output logic [AWIDTH-1:0] rf_read1regsel,
  output logic [AWIDTH-1:0] rf_read2regsel,
  input  logic [DWIDTH-1:0] rf_read1data,
  input  logic [DWIDTH-1:0] rf_read2data,
  output logic [DWIDTH-1:0] rd1_data,
  output logic [DWIDTH-1:0] rd2_data,
  output logic [CNTW-1:0]   a_cnt,
  output logic [CNTW-1:0]   b_cnt
);
  localparam int NRD = 2;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e prio, prio_nxt;
  logic  a_fire, b_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= PRIO_A;
    else        prio <= prio_nxt;
  end

  // Grant goes to the lone valid requester, or to the prio holder on contention.
  always_comb begin
    req.a_ready = 1'b0;
    req.b_ready = 1'b0;
    prio_nxt    = prio;
    if (!req.hold) begin
      req.a_ready = req.a_valid && (!req.b_valid || prio == PRIO_A);
      req.b_ready = req.b_valid && (!req.a_valid || prio == PRIO_B);
    end
    a_fire = req.a_valid && req.a_ready;
    b_fire = req.b_valid && req.b_ready;
    if (a_fire)      prio_nxt = PRIO_B;
    else if (b_fire) prio_nxt = PRIO_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write       <= 1'b0;
      rf_writeregsel <= '0;
      rf_writedata   <= '0;
    end else if (a_fire) begin
      rf_write       <= 1'b1;
      rf_writeregsel <= req.a_sel;
      rf_writedata   <= req.a_data;
    end else if (b_fire) begin
      rf_write       <= 1'b1;
      rf_writeregsel <= req.b_sel;
      rf_writedata   <= req.b_data;
    end else begin
      rf_write       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_fire) a_cnt <= a_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      if (b_fire) b_cnt <= b_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  logic [NRD-1:0][AWIDTH-1:0] rd_sel_v;
  logic [NRD-1:0][DWIDTH-1:0] rf_rdata_v;
  logic [NRD-1:0][DWIDTH-1:0] rd_data_v;

  assign rd_sel_v   = {rd2_sel, rd1_sel};
  assign rf_rdata_v = {rf_read2data, rf_read1data};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
`ifdef RF_BYPASS_EN
    // Forward the write sitting in the output stage so readers see it this cycle.
    assign rd_data_v[p] = (rf_write && rf_writeregsel == rd_sel_v[p])
                          ? rf_writedata : rf_rdata_v[p];
`else
    assign rd_data_v[p] = rf_rdata_v[p];
`endif
  end

  assign rf_read1regsel = rd1_sel;
  assign rf_read2regsel = rd2_sel;
  assign rd1_data       = rd_data_v[0];
  assign rd2_data       = rd_data_v[1];
endmodule
